// File: rtl/mem_skew.sv
// Row-addressed operand store that replays its contents as a rhombus-skewed stream,
// one element per row lane per beat, with zero padding outside each row's window.
module mem_skew #(
  parameter int unsigned BITS_AB = 8,
  parameter int unsigned DIM     = 8,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [$clog2(DIM)-1:0]    wr_row,
  input  logic signed [BITS_AB-1:0] wr_data [DEPTH],
  input  logic                      start,
  input  logic                      stall,
  output logic signed [BITS_AB-1:0] Aout [DIM],
  output logic                      out_valid,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned TW = $clog2(DEPTH + DIM);
  localparam int unsigned RW = $clog2(DIM);
  localparam logic [TW-1:0] LastBeat = TW'(DEPTH + DIM - 2);

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  state_e                      state_q, state_d;
  logic [TW-1:0]               t_q, t_d;
  logic                        valid_q, valid_d;
  logic                        done_q, done_d;
  logic signed [BITS_AB-1:0]   mem_q [DIM][DEPTH];
  logic signed [BITS_AB-1:0]   mem_d [DIM][DEPTH];
  logic signed [BITS_AB-1:0]   aout_q [DIM];
  logic signed [BITS_AB-1:0]   aout_d [DIM];
  logic                        load;
  logic [TW-1:0]               t_load;

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    valid_d = valid_q;
    done_d  = done_q;
    mem_d   = mem_q;
    aout_d  = aout_q;
    load    = 1'b0;
    t_load  = '0;

    unique case (state_q)
      StIdle: begin
        // Rows beyond DIM never match, so out-of-range writes fall through.
        if (wr_en) begin
          for (int r = 0; r < DIM; r++) begin
            if (wr_row == RW'(r)) mem_d[r] = wr_data;
          end
        end
        if (start) begin
          state_d = StStream;
          t_d     = '0;
          valid_d = 1'b1;
          done_d  = (LastBeat == '0);
          load    = 1'b1;
          t_load  = '0;
        end
      end
      StStream: begin
        if (!stall) begin
          if (t_q == LastBeat) begin
            state_d = StIdle;
            t_d     = '0;
            valid_d = 1'b0;
            done_d  = 1'b0;
            for (int r = 0; r < DIM; r++) aout_d[r] = '0;
          end else begin
            t_d    = t_q + TW'(1);
            done_d = ((t_q + TW'(1)) == LastBeat);
            load   = 1'b1;
            t_load = t_q + TW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Skew is taken from the next-state memory so a write sampled with start is visible.
    if (load) begin
      for (int r = 0; r < DIM; r++) begin
        aout_d[r] = '0;
        for (int k = 0; k < DEPTH; k++) begin
          if (int'(t_load) == r + k) aout_d[r] = mem_d[r][k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      t_q     <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int r = 0; r < DIM; r++) begin
        aout_q[r] <= '0;
        for (int k = 0; k < DEPTH; k++) mem_q[r][k] <= '0;
      end
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      aout_q  <= aout_d;
      mem_q   <= mem_d;
    end
  end

  assign Aout      = aout_q;
  assign out_valid = valid_q;
  assign busy      = (state_q == StStream);
  assign done      = done_q;

endmodule

// File: tb/tb_mem_skew.sv
// Directed bench for mem_skew: a model memory produces expected beats into a queue at
// start time; each observed beat pops and compares, stalled cycles must hold.
module tb_mem_skew;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, wr_en, start, stall;
  logic [1:0] wr_row;
  logic signed [7:0] wr_data [4];
  logic signed [7:0] aout [4];
  logic out_valid, busy, done;

  logic wr_en2, start2, stall2;
  logic [1:0] wr_row2;
  logic signed [7:0] wr_data2 [5];
  logic signed [7:0] aout2 [3];
  logic out_valid2, busy2, done2;

  mem_skew #(.BITS_AB(8), .DIM(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
    .start(start), .stall(stall), .Aout(aout), .out_valid(out_valid), .busy(busy),
    .done(done)
  );

  mem_skew #(.BITS_AB(8), .DIM(3), .DEPTH(5)) dut2 (
    .clk(clk), .rst(rst), .wr_en(wr_en2), .wr_row(wr_row2), .wr_data(wr_data2),
    .start(start2), .stall(stall2), .Aout(aout2), .out_valid(out_valid2), .busy(busy2),
    .done(done2)
  );

  int n_cmp = 0;
  int n_err = 0;
  int m1 [4][4];
  int m2 [3][5];
  logic [32:0] q1 [$];
  logic [24:0] q2 [$];
  logic [31:0] obs [16];
  logic [31:0] ref1 [7];
  logic [31:0] last_a;
  logic last_done;
  logic was_valid = 1'b0;
  int beat_idx, valid_cycles, idle_run, gap_last;

  task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic logic [31:0] pack1();
    logic [31:0] v;
    for (int r = 0; r < 4; r++) v[r*8 +: 8] = aout[r];
    return v;
  endfunction

  function automatic logic [23:0] pack2();
    logic [23:0] v;
    for (int r = 0; r < 3; r++) v[r*8 +: 8] = aout2[r];
    return v;
  endfunction

  task automatic push1();
    logic [32:0] e;
    for (int t = 0; t < 7; t++) begin
      e = '0;
      for (int r = 0; r < 4; r++)
        if (t - r >= 0 && t - r < 4) e[r*8 +: 8] = 8'(m1[r][t-r]);
      e[32] = (t == 6);
      q1.push_back(e);
    end
  endtask

  task automatic push2();
    logic [24:0] e;
    for (int t = 0; t < 7; t++) begin
      e = '0;
      for (int r = 0; r < 3; r++)
        if (t - r >= 0 && t - r < 5) e[r*8 +: 8] = 8'(m2[r][t-r]);
      e[24] = (t == 6);
      q2.push_back(e);
    end
  endtask

  // One clock of dut; inputs are changed by the caller only after this returns.
  task automatic tick();
    logic st;
    logic [31:0] cur;
    logic [32:0] e;
    st = stall;
    @(posedge clk);
    #1;
    cur = pack1();
    check("busy_vs_valid", busy, out_valid);
    if (out_valid === 1'b1) begin
      valid_cycles++;
      if (!was_valid) gap_last = idle_run;
      idle_run = 0;
      if (!st || !was_valid) begin
        check("beat_expected", 64'(q1.size() != 0), 1);
        if (q1.size() != 0) begin
          e = q1.pop_front();
          check("aout_beat", cur, e[31:0]);
          check("done_beat", done, e[32]);
          if (beat_idx < 16) obs[beat_idx] = cur;
          beat_idx++;
        end
      end else begin
        check("aout_hold", cur, last_a);
        check("done_hold", done, last_done);
      end
      last_a = cur;
      last_done = done;
    end else begin
      idle_run++;
      check("idle_aout", cur, 0);
      check("idle_done", done, 0);
    end
    was_valid = (out_valid === 1'b1);
  endtask

  task automatic start_stream();
    beat_idx = 0;
    valid_cycles = 0;
    start = 1'b1;
    push1();
    tick();
    start = 1'b0;
  endtask

  task automatic drain(input int maxc);
    for (int c = 0; c < maxc && out_valid === 1'b1; c++) tick();
    check("stream_ended", out_valid, 0);
    check("queue_drained", q1.size(), 0);
  endtask

  task automatic run2();
    int beats = 0;
    int first2 = -1;
    logic [24:0] e;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      start2 = 1'b0;
      if (out_valid2 === 1'b1) begin
        check("d2_beat_expected", 64'(q2.size() != 0), 1);
        if (q2.size() != 0) begin
          e = q2.pop_front();
          check("d2_aout_beat", pack2(), e[23:0]);
          check("d2_done_beat", done2, e[24]);
        end
        if (first2 < 0 && aout2[2] != 0) first2 = beats;
        beats++;
      end else if (beats > 0) begin
        break;
      end
    end
    check("d2_beats", beats, 7);
    check("d2_row2_first", first2, 2);
    check("d2_queue_drained", q2.size(), 0);
    check("d2_idle_busy", busy2, 0);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; start = 1'b0; stall = 1'b0; wr_row = '0;
    wr_en2 = 1'b0; start2 = 1'b0; stall2 = 1'b0; wr_row2 = '0;
    for (int k = 0; k < 4; k++) wr_data[k] = '0;
    for (int k = 0; k < 5; k++) wr_data2[k] = '0;
    for (int r = 0; r < 4; r++) for (int k = 0; k < 4; k++) m1[r][k] = 0;
    for (int r = 0; r < 3; r++) for (int k = 0; k < 5; k++) m2[r][k] = 0;
    beat_idx = 0; valid_cycles = 0; idle_run = 0; gap_last = -1;

    tick();
    tick();
    check("reset_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    rst = 1'b0;

    // Load rows with 10r+k+1.
    for (int r = 0; r < 4; r++) begin
      wr_en = 1'b1;
      wr_row = 2'(r);
      for (int k = 0; k < 4; k++) begin
        wr_data[k] = 8'(10 * r + k + 1);
        m1[r][k] = 10 * r + k + 1;
      end
      tick();
    end
    wr_en = 1'b0;

    start_stream();
    drain(20);
    check("s1_valid_cycles", valid_cycles, 7);
    check("s1_beat0", obs[0], 32'h0000_0001);
    check("s1_beat3", obs[3], 32'h1f16_0d04);
    check("s1_beat6", obs[6], 32'h2200_0000);
    for (int i = 0; i < 7; i++) ref1[i] = obs[i];

    // Back-to-back start on the single idle cycle; a start mid-stream is ignored.
    start_stream();
    check("b2b_gap", gap_last, 1);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    drain(20);
    check("s2_valid_cycles", valid_cycles, 7);
    for (int i = 0; i < 7; i++) check("s2_same_as_s1", obs[i], ref1[i]);

    // Stall three cycles on beat 2.
    start_stream();
    tick();
    tick();
    stall = 1'b1;
    tick();
    tick();
    tick();
    stall = 1'b0;
    drain(20);
    check("stall_valid_cycles", valid_cycles, 10);
    check("stall_beats", beat_idx, 7);

    // Write during a stream is dropped.
    start_stream();
    tick();
    wr_en = 1'b1;
    wr_row = 2'd1;
    for (int k = 0; k < 4; k++) wr_data[k] = 8'(-(k + 1));
    tick();
    tick();
    wr_en = 1'b0;
    drain(20);
    start_stream();
    drain(20);
    check("old_row1_beat1", obs[1][15:8], 8'd11);

    // Write with start in IDLE is visible to that stream.
    wr_en = 1'b1;
    for (int k = 0; k < 4; k++) m1[1][k] = -(k + 1);
    start_stream();
    wr_en = 1'b0;
    drain(20);
    check("new_row1_beat1", obs[1][15:8], 8'hff);
    check("new_row1_beat4", obs[4][15:8], 8'hfc);

    // Reset mid-stream at beat 3.
    start_stream();
    tick();
    tick();
    tick();
    check("pre_reset_beat", beat_idx, 4);
    rst = 1'b1;
    q1.delete();
    tick();
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    for (int r = 0; r < 4; r++) for (int k = 0; k < 4; k++) m1[r][k] = 0;
    tick();
    start_stream();
    drain(20);
    check("zero_valid_cycles", valid_cycles, 7);

    // DIM=3 / DEPTH=5 instance: out-of-range row write is ignored.
    for (int r = 0; r < 3; r++) begin
      wr_en2 = 1'b1;
      wr_row2 = 2'(r);
      for (int k = 0; k < 5; k++) begin
        wr_data2[k] = 8'(10 * r + k + 1);
        m2[r][k] = 10 * r + k + 1;
      end
      @(posedge clk);
      #1;
    end
    wr_row2 = 2'd3;
    for (int k = 0; k < 5; k++) wr_data2[k] = 8'sd99;
    @(posedge clk);
    #1;
    wr_en2 = 1'b0;
    start2 = 1'b1;
    push2();
    run2();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_skew.md
MEM_SKEW -- requirements
Module: mem_skew

Interface
REQ-001 SHALL have parameter BITS_AB, default 8, signed element width in bits.
REQ-002 SHALL have parameter DIM, default 8, number of rows and output lanes (systolic array height).
REQ-003 SHALL have parameter DEPTH, default 8, number of elements stored per row (K dimension).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port wr_en  input  1  write strobe for one full row.
REQ-007 SHALL have port wr_row  input  $clog2(DIM)  row index to write.
REQ-008 SHALL have port wr_data  input  signed BITS_AB x DEPTH array  row contents; element k goes to column k.
REQ-009 SHALL have port start  input  1  single-cycle request to begin a skewed stream.
REQ-010 SHALL have port stall  input  1  holds the stream in place while high.
REQ-011 SHALL have port Aout  output  signed BITS_AB x DIM array  one element per row lane, registered.
REQ-012 SHALL have port out_valid  output  1  Aout carries a stream beat.
REQ-013 SHALL have port busy  output  1  high while in STREAM.
REQ-014 SHALL have port done  output  1  one-cycle pulse coinciding with the final stream beat.

Function
REQ-015 SHALL store DIM x DEPTH signed elements in registers; contents persist across streams until overwritten or reset.
REQ-016 SHALL implement FSM states IDLE and STREAM only.
REQ-017 SHALL, in IDLE with wr_en=1, write wr_data into row wr_row at the clock edge; other rows unchanged.
REQ-018 SHALL ignore wr_en while in STREAM; memory unchanged.
REQ-019 SHALL ignore wr_en when wr_row >= DIM (non-power-of-two DIM).
REQ-020 SHALL transition IDLE->STREAM on start=1, clearing beat counter t to 0; start in STREAM is ignored.
REQ-021 SHALL, on simultaneous wr_en and start in IDLE, commit the write and make it visible to the stream that starts.
REQ-022 SHALL produce beats t = 0 .. DEPTH+DIM-2 (DEPTH+DIM-1 beats total), the first in the cycle after start is sampled.
REQ-023 SHALL drive, on beat t, Aout[r] = mem[r][t-r] when 0 <= t-r < DEPTH, else 0 (rhombus skew, zero padding).
REQ-024 SHALL assert out_valid=1 and busy=1 on every beat; out_valid=0 and Aout all zero in IDLE.
REQ-025 SHALL, while stall=1 in STREAM, hold t, Aout, out_valid and done unchanged; no beat is consumed.
REQ-026 SHALL assert done together with beat t = DEPTH+DIM-2, then return to IDLE at the next unstalled edge.
REQ-027 SHALL accept a new start in the cycle immediately after returning to IDLE (back-to-back streams, one idle cycle minimum).
REQ-028 SHALL size the beat counter as $clog2(DEPTH+DIM) bits with no wrap before the terminal beat.
REQ-029 SHALL leave elements unmodified (no rounding or sign change); only zero-insertion is performed.

Reset
REQ-030 SHALL, with rst=1 at a clock edge, clear all stored elements to 0, enter IDLE, set t=0, drive Aout all 0, out_valid=0, busy=0, done=0.
REQ-031 SHALL give rst priority over start, wr_en and stall; reset mid-stream aborts the stream with no done pulse.

Verification
REQ-032 SHALL pass: DIM=4, DEPTH=4, rows r loaded with {10r+1,10r+2,10r+3,10r+4}, start -> 7 beats; beat 0 Aout={1,0,0,0}, beat 3 Aout={4,13,22,31}, beat 6 Aout={0,0,0,34}, done on beat 6 only.
REQ-033 SHALL pass: stall=1 for 3 cycles at beat 2 -> beat 2 values held 4 cycles total, stream ends 3 cycles later, still 7 distinct beats.
REQ-034 SHALL pass: wr_en row 1 = {-1,-2,-3,-4} during STREAM -> current and next streams show old row 1 values; same write in IDLE with start -> new values from beat 1.
REQ-035 SHALL pass: rst asserted at beat 3 -> next cycle out_valid=0, busy=0, Aout all 0, no done; new start streams all zeros.
REQ-036 SHALL pass: start asserted on the cycle after done -> second stream identical to first, with exactly one non-valid cycle between them.
REQ-037 SHALL pass: DIM=3, DEPTH=5, wr_row=3 write -> ignored; stream shows 7 beats with row 2 first nonzero on beat 2.
